// File: rtl/tdc_sweep_ctrl.sv
// Calibration sweep sequencer for the thermometer-code TDC: steps the stop-path delay code,
// arms the start stage, accumulates NSAMP popcount samples per code and reports one sum per code.
module tdc_sweep_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int NSAMP_LOG2 = 4,
   parameter int SUM_W      = 4 + NSAMP_LOG2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_start,
   input  logic             cmd_abort,
   input  logic [4:0]       code_first,
   input  logic [4:0]       code_last,
   input  logic [7:0]       term_in,
   output logic [4:0]       delay_en,
   output logic             tdc_arm,
   output logic             res_valid,
   output logic [4:0]       res_code,
   output logic [SUM_W-1:0] res_sum,
   output logic             res_bubble,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE, DISARM, ARM, SETTLE, SAMPLE, REPORT, FIN
   } state_t;

   localparam int SCW = $clog2(SETTLE_CYC) + 1;
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 2);

   state_t state, state_nxt;

   logic [7:0]            term_meta;
   logic [7:0]            term_sync;
   logic [7:0]            term_inc;
   logic                  term_bubble;
   logic [3:0]            term_ones;
   logic [4:0]            cur_code;
   logic [4:0]            last_code;
   logic [SCW-1:0]        settle_cnt;
   logic [NSAMP_LOG2-1:0] samp_cnt;
   logic [SUM_W-1:0]      acc;
   logic                  bubble_flag;
   logic                  start_ok;
   logic                  last_reached;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   // A legal thermometer word fills from the LSB, so adding one clears every set bit.
   assign term_inc     = term_sync + 8'd1;
   assign term_bubble  = |(term_sync & term_inc);
   assign term_ones    = popcount8(term_sync);
   assign start_ok     = cmd_start && !cmd_abort;
   // Covers an inverted range too: only the first code is measured and the code never wraps.
   assign last_reached = (cur_code >= last_code);

   assign tdc_arm = (state == ARM) || (state == SETTLE) || (state == SAMPLE);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_meta <= 8'd0;
         term_sync <= 8'd0;
      end else begin
         term_meta <= term_in;
         term_sync <= term_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = DISARM;
         DISARM:  state_nxt = ARM;
         ARM:     state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (samp_cnt == '1) ? REPORT : DISARM;
         REPORT:  state_nxt = last_reached ? FIN : DISARM;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && cmd_abort) begin
         state_nxt = IDLE;
      end
   end

   // Result and done strobes are registered, so they appear the cycle after REPORT/FIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_code    <= 5'd0;
         last_code   <= 5'd0;
         settle_cnt  <= '0;
         samp_cnt    <= '0;
         acc         <= '0;
         bubble_flag <= 1'b0;
         delay_en    <= 5'd0;
         res_valid   <= 1'b0;
         res_code    <= 5'd0;
         res_sum     <= '0;
         res_bubble  <= 1'b0;
         done        <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  cur_code    <= code_first;
                  last_code   <= code_last;
                  acc         <= '0;
                  bubble_flag <= 1'b0;
                  samp_cnt    <= '0;
               end
            end
            DISARM: delay_en <= cur_code;
            ARM:    settle_cnt <= '0;
            SETTLE: settle_cnt <= settle_cnt + 1'b1;
            SAMPLE: begin
               acc         <= acc + SUM_W'(term_ones);
               bubble_flag <= bubble_flag | term_bubble;
               samp_cnt    <= samp_cnt + 1'b1;
            end
            REPORT: begin
               res_valid   <= 1'b1;
               res_code    <= cur_code;
               res_sum     <= acc;
               res_bubble  <= bubble_flag;
               acc         <= '0;
               bubble_flag <= 1'b0;
               samp_cnt    <= '0;
               if (!last_reached) begin
                  cur_code <= cur_code + 5'd1;
               end
            end
            FIN:     done <= !cmd_abort;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// Directed bench for tdc_sweep_ctrl: expected results are queued at stimulus time and
// compared by a monitor as each res_valid strobe appears.
module tb_tdc_sweep_ctrl;

   typedef struct {
      logic [4:0] code;
      logic [7:0] sum;
      logic       bubble;
   } result_t;

   logic       clk;
   logic       rst_n;
   logic       cmd_start;
   logic       cmd_abort;
   logic [4:0] code_first;
   logic [4:0] code_last;
   logic [7:0] term_in;
   logic [4:0] delay_en;
   logic       tdc_arm;
   logic       res_valid;
   logic [4:0] res_code;
   logic [7:0] res_sum;
   logic       res_bubble;
   logic       busy;
   logic       done;

   result_t expQ[$];
   result_t expItem;
   int      checks;
   int      errors;
   int      cyc;
   int      doneCount;
   int      lastValidCyc;
   int      startCyc;

   tdc_sweep_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_start  (cmd_start),
      .cmd_abort  (cmd_abort),
      .code_first (code_first),
      .code_last  (code_last),
      .term_in    (term_in),
      .delay_en   (delay_en),
      .tdc_arm    (tdc_arm),
      .res_valid  (res_valid),
      .res_code   (res_code),
      .res_sum    (res_sum),
      .res_bubble (res_bubble),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic reportTimeout(input string tag);
      checks++;
      errors++;
      $display("[TB] FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic pushResult(input int code, input int sum, input logic bub);
      result_t r;
      r.code   = 5'(code);
      r.sum    = 8'(sum);
      r.bubble = bub;
      expQ.push_back(r);
   endtask

   // Drives one start pulse at a falling edge and remembers the cycle it was presented in.
   task automatic applyStimulus(input int first, input int last);
      @(negedge clk);
      code_first = 5'(first);
      code_last  = 5'(last);
      cmd_start  = 1'b1;
      startCyc   = cyc;
      @(negedge clk);
      cmd_start  = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int base;
      int n;
      base = doneCount;
      n = 0;
      while (doneCount == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (doneCount == base) reportTimeout(tag);
   endtask

   task automatic waitQueueBelow(input string tag, input int size, input int budget);
      int n;
      n = 0;
      while (expQ.size() >= size && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() >= size) reportTimeout(tag);
   endtask

   // Scoreboard side: every result strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result observed code=%0d expected none", res_code);
         end else begin
            expItem = expQ.pop_front();
            checkOutput("res_code", 32'(res_code), 32'(expItem.code));
            checkOutput("res_sum", 32'(res_sum), 32'(expItem.sum));
            checkOutput("res_bubble", 32'(res_bubble), 32'(expItem.bubble));
            checkOutput("delay_en_at_result", 32'(delay_en), 32'(expItem.code));
         end
         lastValidCyc = cyc;
      end
      if (rst_n && done) begin
         doneCount++;
         checkOutput("done_after_result", 32'(cyc), 32'(lastValidCyc + 1));
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_delay_en"}, 32'(delay_en), 32'd0);
      checkOutput({tag, "_tdc_arm"}, 32'(tdc_arm), 32'd0);
      checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      checkOutput({tag, "_res_code"}, 32'(res_code), 32'd0);
      checkOutput({tag, "_res_sum"}, 32'(res_sum), 32'd0);
      checkOutput({tag, "_res_bubble"}, 32'(res_bubble), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int base;
      int n;
      checks       = 0;
      errors       = 0;
      doneCount    = 0;
      lastValidCyc = -10;
      startCyc     = 0;
      rst_n        = 1'b0;
      cmd_start    = 1'b0;
      cmd_abort    = 1'b0;
      code_first   = 5'd0;
      code_last    = 5'd0;
      term_in      = 8'h00;

      // Reset state
      #1;
      checkAllZero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkAllZero("after_reset");

      // Single code, half-full thermometer
      $display("[TB] step 1: single code 3");
      term_in = 8'h0F;
      base = doneCount;
      pushResult(3, 64, 1'b0);
      applyStimulus(3, 3);
      waitDone("step1_done", 400);
      checkOutput("step1_queue_empty", 32'(expQ.size()), 32'd0);
      checkOutput("step1_done_count", 32'(doneCount - base), 32'd1);
      checkOutput("step1_busy_idle", 32'(busy), 32'd0);

      // Full range, full-scale thermometer
      $display("[TB] step 2: full sweep 0..31");
      term_in = 8'hFF;
      for (int i = 0; i < 32; i++) pushResult(i, 128, 1'b0);
      applyStimulus(0, 31);
      waitDone("step2_done", 32 * 97 + 100);
      checkOutput("step2_queue_empty", 32'(expQ.size()), 32'd0);
      checkOutput("step2_delay_en_last", 32'(delay_en), 32'd31);

      // Bubble pattern only while code 5 is measured
      $display("[TB] step 3: bubble on code 5");
      term_in = 8'h0F;
      pushResult(4, 64, 1'b0);
      pushResult(5, 32, 1'b1);
      pushResult(6, 64, 1'b0);
      applyStimulus(4, 6);
      waitQueueBelow("step3_code4", 3, 200);
      term_in = 8'b0000_0101;
      waitQueueBelow("step3_code5", 2, 200);
      term_in = 8'h0F;
      waitDone("step3_done", 300);
      checkOutput("step3_queue_empty", 32'(expQ.size()), 32'd0);

      // Abort during SETTLE of code 2
      $display("[TB] step 4: abort on code 2");
      pushResult(0, 64, 1'b0);
      pushResult(1, 64, 1'b0);
      applyStimulus(0, 4);
      waitQueueBelow("step4_results", 1, 400);
      n = 0;
      while (!(delay_en == 5'd2 && tdc_arm) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!(delay_en == 5'd2 && tdc_arm)) reportTimeout("step4_arm_code2");
      @(negedge clk);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      checkOutput("step4_busy_after_abort", 32'(busy), 32'd0);
      checkOutput("step4_arm_after_abort", 32'(tdc_arm), 32'd0);
      base = doneCount;
      repeat (300) @(negedge clk);
      checkOutput("step4_no_done", 32'(doneCount), 32'(base));
      checkOutput("step4_queue_empty", 32'(expQ.size()), 32'd0);

      // Inverted range; a start while busy must not disturb the sweep
      $display("[TB] step 5: inverted range with stray start");
      term_in = 8'h0F;
      base = doneCount;
      pushResult(10, 64, 1'b0);
      applyStimulus(10, 4);
      repeat (20) @(negedge clk);
      code_first = 5'd20;
      code_last  = 5'd25;
      cmd_start  = 1'b1;
      @(negedge clk);
      cmd_start  = 1'b0;
      waitDone("step5_done", 300);
      repeat (200) @(negedge clk);
      checkOutput("step5_queue_empty", 32'(expQ.size()), 32'd0);
      checkOutput("step5_done_count", 32'(doneCount - base), 32'd1);
      checkOutput("step5_delay_en_kept", 32'(delay_en), 32'd10);
      checkOutput("step5_busy_idle", 32'(busy), 32'd0);

      // First-result latency, then reset in the middle of the next code
      $display("[TB] step 6: latency and mid-sweep reset");
      pushResult(7, 64, 1'b0);
      applyStimulus(7, 9);
      waitQueueBelow("step6_first_result", 1, 300);
      checkOutput("step6_latency", 32'(lastValidCyc - startCyc), 32'd98);
      repeat (40) @(negedge clk);
      checkOutput("step6_busy_mid", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("step6_idle_after_reset", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
